// File: rtl/checker_ctlif_mc_pkg.sv
// Shared encodings for the multi-channel checker control interface:
// channel states, engine mode codes, CSR register map and STAT/CTRL bit positions.
package checker_ctlif_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } chan_state_t;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_READ   = 2'd2,
        MODE_DUMMY  = 2'd3
    } mode_t;

    localparam logic [5:0] REG_ADDR_LO   = 6'd0;
    localparam logic [5:0] REG_ADDR_HI   = 6'd1;
    localparam logic [5:0] REG_STAT      = 6'd2;
    localparam logic [5:0] REG_CTRL      = 6'd3;
    localparam logic [5:0] REG_DATA_LO   = 6'd4;
    localparam logic [5:0] REG_DATA_HI   = 6'd5;
    localparam logic [5:0] REG_TMO_LIMIT = 6'd6;
    localparam logic [5:0] REG_TMO_COUNT = 6'd7;

    localparam logic [3:0] GLOBAL_PAGE = 4'hF;
    localparam logic [5:0] REG_GSTAT   = 6'd0;

    localparam int STAT_END     = 0;
    localparam int STAT_ERROR   = 1;
    localparam int STAT_IRQ     = 2;
    localparam int STAT_TIMEOUT = 3;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_START   = 3;

endpackage

// File: rtl/checker_ctlif_mc_chan.sv
// One checker channel: run/irq-handshake FSM, CSR registers, event flags and watchdog.
// Watchdog registers exist only when CHECKER_CTLIF_MC_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | engine stopped, configuration writable
// RUN     | engine running, watchdog counting
// WAIT    | engine raised irq, waiting for software to clear STAT.irq
// ACK     | one-cycle acknowledge pulse to the engine, then back to RUN
module checker_ctlif_mc_chan
    import checker_ctlif_mc_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int TMO_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_en,
    input  logic [5:0]        reg_sel,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [1:0]        mode_mode,
    output logic              mode_start,
    output logic [ADDR_W-1:0] mode_addr,
    input  logic              mode_end,
    input  logic [63:0]       mode_data,
    input  logic              mode_irq,
    output logic              mode_ack,
    input  logic              mode_error,
    output logic              pending
);

    chan_state_t      state;
    mode_t            mode_q;
    logic             start_q;
    logic             irq_en_q;
    logic [3:0]       ev_q;
    logic [3:0]       ev_set;
    logic [3:0]       ev_clr;
    logic [TMO_W-1:0] tmo_limit;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic [63:0]      addr64;
    logic             is_idle;
    logic             wr_addr_lo;
    logic             wr_addr_hi;
    logic             wr_stat;
    logic             wr_ctrl;

    assign is_idle    = (state == ST_IDLE);
    assign wr_addr_lo = wr_en && (reg_sel == REG_ADDR_LO);
    assign wr_addr_hi = wr_en && (reg_sel == REG_ADDR_HI);
    assign wr_stat    = wr_en && (reg_sel == REG_STAT);
    assign wr_ctrl    = wr_en && (reg_sel == REG_CTRL);
    assign addr64     = 64'(mode_addr);
    assign tmo_hit    = (tmo_limit != '0) && (tmo_cnt == tmo_limit);

    assign mode_mode  = mode_q;
    assign mode_start = start_q;
    assign pending    = (|ev_q) && irq_en_q;

    // RUN exit priority is resolved here once; the FSM only follows ev_set.
    always_comb begin
        ev_set = '0;
        ev_clr = '0;
        if (state == ST_RUN) begin
            if (mode_end)
                ev_set[STAT_END] = 1'b1;
            else if (!start_q)
                ev_set = '0;
            else if (mode_error)
                ev_set[STAT_ERROR] = 1'b1;
            else if (tmo_hit)
                ev_set[STAT_TIMEOUT] = 1'b1;
            else if (mode_irq)
                ev_set[STAT_IRQ] = 1'b1;
        end
        if ((state == ST_WAIT) && !start_q)
            ev_clr[STAT_IRQ] = 1'b1;
        if (wr_stat && (is_idle || (state == ST_WAIT)))
            ev_clr = ev_clr | wdata[3:0];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            start_q   <= 1'b0;
            mode_q    <= MODE_SINGLE;
            irq_en_q  <= 1'b0;
            ev_q      <= '0;
            mode_addr <= '0;
            mode_ack  <= 1'b0;
        end else begin
            mode_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_q)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (ev_set[STAT_END] || ev_set[STAT_ERROR] || ev_set[STAT_TIMEOUT]) begin
                        state   <= ST_IDLE;
                        start_q <= 1'b0;
                    end else if (!start_q) begin
                        state <= ST_IDLE;
                    end else if (ev_set[STAT_IRQ]) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!start_q) begin
                        state <= ST_IDLE;
                    end else if (!ev_q[STAT_IRQ]) begin
                        state    <= ST_ACK;
                        mode_ack <= 1'b1;
                    end
                end
                ST_ACK: state <= ST_RUN;
                default: state <= ST_IDLE;
            endcase

            // Software start write lands after the FSM so it overrides a same-cycle clear.
            if (wr_ctrl) begin
                start_q <= wdata[CTRL_START];
                if (is_idle) begin
                    mode_q   <= mode_t'(wdata[CTRL_MODE_LO +: 2]);
                    irq_en_q <= wdata[CTRL_IRQ_EN];
                end
            end
            if (wr_addr_lo && is_idle)
                mode_addr <= ADDR_W'({addr64[63:32], wdata});
            if (wr_addr_hi && is_idle)
                mode_addr <= ADDR_W'({wdata, addr64[31:0]});

            ev_q <= (ev_q & ~ev_clr) | ev_set;
        end
    end

`ifdef CHECKER_CTLIF_MC_TIMEOUT_EN
    logic wr_tmo_limit;
    assign wr_tmo_limit = wr_en && (reg_sel == REG_TMO_LIMIT);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmo_limit <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (wr_tmo_limit && is_idle)
                tmo_limit <= TMO_W'(wdata);
            if (is_idle && start_q)
                tmo_cnt <= '0;
            else if ((state == ST_RUN) && !tmo_hit && (tmo_cnt != '1))
                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_limit = '0;
    assign tmo_cnt   = '0;
`endif

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_ADDR_LO:   rdata = addr64[31:0];
            REG_ADDR_HI:   rdata = addr64[63:32];
            REG_STAT:      rdata = {28'd0, ev_q};
            REG_CTRL:      rdata = {28'd0, start_q, mode_q, irq_en_q};
            REG_DATA_LO:   rdata = mode_data[31:0];
            REG_DATA_HI:   rdata = mode_data[63:32];
            REG_TMO_LIMIT: rdata = 32'(tmo_limit);
            REG_TMO_COUNT: rdata = 32'(tmo_cnt);
            default:       rdata = '0;
        endcase
    end

endmodule

// File: rtl/checker_ctlif_mc.sv
// CSR window onto NCHAN checker channels: bank/channel decode, registered read mux,
// GSTAT and the aggregated irq. Watchdog support: define CHECKER_CTLIF_MC_TIMEOUT_EN.
module checker_ctlif_mc
    import checker_ctlif_mc_pkg::*;
#(
    parameter logic [3:0] csr_addr = 4'h0,
    parameter int          NCHAN    = 2,
    parameter int          ADDR_W   = 64,
    parameter int          TMO_W    = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [13:0]              csr_a,
    input  logic                     csr_we,
    input  logic [31:0]              csr_di,
    output logic [31:0]              csr_do,
    output logic [2*NCHAN-1:0]       mode_mode,
    output logic [NCHAN-1:0]         mode_start,
    output logic [ADDR_W*NCHAN-1:0]  mode_addr,
    input  logic [NCHAN-1:0]         mode_end,
    input  logic [64*NCHAN-1:0]      mode_data,
    input  logic [NCHAN-1:0]         mode_irq,
    output logic [NCHAN-1:0]         mode_ack,
    input  logic [NCHAN-1:0]         mode_error,
    output logic                     irq
);

    logic        sel;
    logic [3:0]  chan_idx;
    logic [5:0]  reg_idx;
    logic [31:0] rd_mux;
    logic [31:0] chan_rdata [NCHAN];
    logic [NCHAN-1:0] pending;

    assign sel      = (csr_a[13:10] == csr_addr);
    assign chan_idx = csr_a[9:6];
    assign reg_idx  = csr_a[5:0];

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        checker_ctlif_mc_chan #(
            .ADDR_W (ADDR_W),
            .TMO_W  (TMO_W)
        ) u_chan (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .wr_en      (sel && csr_we && (chan_idx == 4'(i))),
            .reg_sel    (reg_idx),
            .wdata      (csr_di),
            .rdata      (chan_rdata[i]),
            .mode_mode  (mode_mode[2*i +: 2]),
            .mode_start (mode_start[i]),
            .mode_addr  (mode_addr[ADDR_W*i +: ADDR_W]),
            .mode_end   (mode_end[i]),
            .mode_data  (mode_data[64*i +: 64]),
            .mode_irq   (mode_irq[i]),
            .mode_ack   (mode_ack[i]),
            .mode_error (mode_error[i]),
            .pending    (pending[i])
        );
    end

    // Channel pages at or above NCHAN (other than the global page) fall through to 0.
    always_comb begin
        rd_mux = '0;
        if (chan_idx == GLOBAL_PAGE) begin
            if (reg_idx == REG_GSTAT)
                rd_mux = 32'(pending);
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (chan_idx == 4'(i))
                    rd_mux = chan_rdata[i];
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            csr_do <= '0;
        else
            csr_do <= sel ? rd_mux : 32'd0;
    end

    assign irq = |pending;

endmodule

// File: tb/tb_checker_ctlif_mc.sv
// Bench for checker_ctlif_mc: behavioural channel model checked every cycle plus
// directed literal expectations. Honours CHECKER_CTLIF_MC_TIMEOUT_EN like the design.
module tb_checker_ctlif_mc;

    localparam int         NCHAN  = 2;
    localparam int         ADDR_W = 64;
    localparam int         TMO_W  = 16;
    localparam logic [3:0] BANK   = 4'h0;
    localparam int unsigned MAXC  = (1 << TMO_W) - 1;
`ifdef CHECKER_CTLIF_MC_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int PH_IDLE = 0, PH_RUN = 1, PH_WAIT = 2, PH_ACK = 3;
    localparam logic [13:0] IDLE_A = 14'h0400;

    logic                    sys_clk = 1'b0;
    logic                    sys_rst = 1'b0;
    logic [13:0]             csr_a   = IDLE_A;
    logic                    csr_we  = 1'b0;
    logic [31:0]             csr_di  = '0;
    logic [31:0]             csr_do;
    logic [2*NCHAN-1:0]      mode_mode;
    logic [NCHAN-1:0]        mode_start;
    logic [ADDR_W*NCHAN-1:0] mode_addr;
    logic [NCHAN-1:0]        mode_end   = '0;
    logic [64*NCHAN-1:0]     mode_data  = {64'hA5A50000_5A5AFFFF, 64'h11223344_55667788};
    logic [NCHAN-1:0]        mode_irq   = '0;
    logic [NCHAN-1:0]        mode_ack;
    logic [NCHAN-1:0]        mode_error = '0;
    logic                    irq;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    checker_ctlif_mc #(
        .csr_addr (BANK),
        .NCHAN    (NCHAN),
        .ADDR_W   (ADDR_W),
        .TMO_W    (TMO_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .csr_a      (csr_a),
        .csr_we     (csr_we),
        .csr_di     (csr_di),
        .csr_do     (csr_do),
        .mode_mode  (mode_mode),
        .mode_start (mode_start),
        .mode_addr  (mode_addr),
        .mode_end   (mode_end),
        .mode_data  (mode_data),
        .mode_irq   (mode_irq),
        .mode_ack   (mode_ack),
        .mode_error (mode_error),
        .irq        (irq)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got 0x%0h want 0x%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ph    [NCHAN];
    logic [63:0] m_addr  [NCHAN];
    logic [1:0]  m_mode  [NCHAN];
    bit          m_start [NCHAN];
    bit          m_irqen [NCHAN];
    bit          m_ack   [NCHAN];
    logic [3:0]  m_ev    [NCHAN];
    int unsigned m_lim   [NCHAN];
    int unsigned m_cnt   [NCHAN];
    logic [31:0] m_do;

    function automatic logic [NCHAN-1:0] m_pend();
        logic [NCHAN-1:0] p;
        p = '0;
        for (int c = 0; c < NCHAN; c++)
            p[c] = (m_ev[c] != 4'd0) && m_irqen[c];
        return p;
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] a);
        int ch;
        int r;
        ch = int'(a[9:6]);
        r  = int'(a[5:0]);
        if (a[13:10] != BANK) return 32'd0;
        if (ch == 15) return (r == 0) ? 32'(m_pend()) : 32'd0;
        if (ch >= NCHAN) return 32'd0;
        case (r)
            0: return m_addr[ch][31:0];
            1: return m_addr[ch][63:32];
            2: return {28'd0, m_ev[ch]};
            3: return {28'd0, m_start[ch], m_mode[ch], m_irqen[ch]};
            4: return mode_data[64*ch +: 32];
            5: return mode_data[64*ch+32 +: 32];
            6: return m_lim[ch];
            7: return m_cnt[ch];
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int c = 0; c < NCHAN; c++) begin
                m_ph[c] = PH_IDLE; m_addr[c] = '0; m_mode[c] = '0; m_start[c] = 0;
                m_irqen[c] = 0; m_ack[c] = 0; m_ev[c] = '0; m_lim[c] = 0; m_cnt[c] = 0;
            end
            m_do = '0;
        end else begin
            logic [31:0] nxt_do;
            nxt_do = m_read(csr_a);
            for (int c = 0; c < NCHAN; c++) begin
                int ph;
                int r;
                bit wr;
                bit at_lim;
                logic [3:0] set_v;
                logic [3:0] clr_v;
                ph     = m_ph[c];
                set_v  = '0;
                clr_v  = '0;
                wr     = csr_we && (csr_a[13:10] == BANK) && (int'(csr_a[9:6]) == c);
                r      = int'(csr_a[5:0]);
                at_lim = TMO_EN && (m_lim[c] != 0) && (m_cnt[c] == m_lim[c]);
                case (ph)
                    PH_IDLE: if (m_start[c]) begin m_ph[c] = PH_RUN; m_cnt[c] = 0; end
                    PH_RUN: begin
                        if (mode_end[c]) begin set_v[0] = 1; m_ph[c] = PH_IDLE; m_start[c] = 0; end
                        else if (!m_start[c]) m_ph[c] = PH_IDLE;
                        else if (mode_error[c]) begin set_v[1] = 1; m_ph[c] = PH_IDLE; m_start[c] = 0; end
                        else if (at_lim) begin set_v[3] = 1; m_ph[c] = PH_IDLE; m_start[c] = 0; end
                        else if (mode_irq[c]) begin set_v[2] = 1; m_ph[c] = PH_WAIT; end
                        if (TMO_EN && !at_lim && m_cnt[c] < MAXC) m_cnt[c]++;
                    end
                    PH_WAIT: begin
                        if (!m_start[c]) begin m_ph[c] = PH_IDLE; clr_v[2] = 1; end
                        else if (!m_ev[c][2]) m_ph[c] = PH_ACK;
                    end
                    default: m_ph[c] = PH_RUN;
                endcase
                if (wr) begin
                    if (r == 0 && ph == PH_IDLE) m_addr[c][31:0] = csr_di;
                    if (r == 1 && ph == PH_IDLE) m_addr[c][63:32] = csr_di;
                    if (r == 2 && (ph == PH_IDLE || ph == PH_WAIT)) clr_v = clr_v | csr_di[3:0];
                    if (r == 3) begin
                        m_start[c] = csr_di[3];
                        if (ph == PH_IDLE) begin m_mode[c] = csr_di[2:1]; m_irqen[c] = csr_di[0]; end
                    end
                    if (r == 6 && TMO_EN && ph == PH_IDLE) m_lim[c] = csr_di[15:0];
                end
                m_ev[c]  = (m_ev[c] & ~clr_v) | set_v;
                m_ack[c] = (m_ph[c] == PH_ACK);
            end
            m_do = nxt_do;
        end
    end

    always @(negedge sys_clk) begin
        chk("csr_do", csr_do, m_do);
        chk("irq", irq, |m_pend());
        for (int c = 0; c < NCHAN; c++) begin
            chk($sformatf("start%0d", c), mode_start[c], m_start[c]);
            chk($sformatf("ack%0d", c), mode_ack[c], m_ack[c]);
            chk($sformatf("mode%0d", c), mode_mode[2*c +: 2], m_mode[c]);
            chk($sformatf("addr%0d", c), mode_addr[ADDR_W*c +: ADDR_W], m_addr[c]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input int ch, input int r, input logic [31:0] d);
        csr_a  = {BANK, 4'(ch), 6'(r)};
        csr_we = 1'b1;
        csr_di = d;
        @(posedge sys_clk);
        @(negedge sys_clk);
        csr_we = 1'b0;
        csr_a  = IDLE_A;
    endtask

    task automatic rd(input int ch, input int r, input logic [31:0] exp, input string nm);
        csr_a = {BANK, 4'(ch), 6'(r)};
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk(nm, csr_do, exp);
        csr_a = IDLE_A;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        #1 sys_rst = 1'b1;
        cyc(2);
        chk("rst_start", mode_start, 0);
        chk("rst_do", csr_do, 0);
        chk("rst_irq", irq, 0);
        sys_rst = 1'b0;
        cyc(1);

        // ch1: address, start, end, W1C
        wr(1, 0, 32'h1000);
        wr(1, 1, 32'hCAFE);
        chk("ch1_addr", mode_addr[ADDR_W +: ADDR_W], 64'h0000CAFE_00001000);
        wr(1, 3, 32'h9);
        chk("ch1_start", mode_start[1], 1);
        cyc(2);
        mode_end[1] = 1'b1;
        cyc(1);
        mode_end[1] = 1'b0;
        chk("ch1_stop", mode_start[1], 0);
        chk("ch1_irq_set", irq, 1);
        rd(1, 2, 32'h1, "ch1_stat_end");
        rd(1, 3, 32'h1, "ch1_ctrl");
        wr(1, 2, 32'h1);
        chk("ch1_irq_clr", irq, 0);
        rd(1, 4, 32'h5A5AFFFF, "ch1_data_lo");
        rd(1, 5, 32'hA5A50000, "ch1_data_hi");
        wr(1, 3, 32'h7);
        chk("ch1_mode_dummy", mode_mode[3:2], 2'd3);
        wr(1, 3, 32'h1);

        // ch0: irq handshake
        wr(0, 3, 32'h9);
        cyc(2);
        mode_irq[0] = 1'b1;
        cyc(1);
        mode_irq[0] = 1'b0;
        rd(0, 2, 32'h4, "ch0_stat_irq");
        chk("ch0_irq_line", irq, 1);
        wr(0, 2, 32'h4);
        chk("ch0_ack_pre", mode_ack[0], 0);
        cyc(1);
        chk("ch0_ack_hi", mode_ack[0], 1);
        cyc(1);
        chk("ch0_ack_lo", mode_ack[0], 0);
        chk("ch0_still_run", mode_start[0], 1);
        wr(0, 0, 32'hDEAD);
        rd(0, 0, 32'h0, "ch0_addr_locked");
        wr(0, 3, 32'h1);
        cyc(1);

`ifdef CHECKER_CTLIF_MC_TIMEOUT_EN
        wr(0, 6, 32'd10);
        wr(0, 3, 32'h8);
        n = 0;
        while (mode_start[0] && n < 40) begin
            cyc(1);
            n++;
        end
        chk("tmo_fired", mode_start[0], 0);
        chk("tmo_cycles", n, 12);
        rd(0, 7, 32'd10, "tmo_count");
        rd(0, 2, 32'h8, "tmo_stat");
        wr(0, 2, 32'h8);
        wr(0, 6, 32'd0);
        rd(0, 6, 32'd0, "tmo_limit_clr");
`else
        n = 0;
        wr(0, 6, 32'd10);
        wr(0, 3, 32'h9);
        cyc(40);
        chk("notmo_running", mode_start[0], 1);
        rd(0, 7, 32'd0, "notmo_count");
        rd(0, 6, 32'd0, "notmo_limit");
        rd(0, 2, 32'd0, "notmo_stat");
        wr(0, 3, 32'h1);
        cyc(1);
`endif

        // end beats error in the same cycle
        wr(0, 3, 32'h9);
        cyc(2);
        mode_end[0]   = 1'b1;
        mode_error[0] = 1'b1;
        cyc(1);
        mode_end[0]   = 1'b0;
        mode_error[0] = 1'b0;
        rd(0, 2, 32'h1, "ch0_end_over_err");
        wr(0, 2, 32'h1);

        // both channels pending
        wr(0, 3, 32'h9);
        wr(1, 3, 32'h9);
        cyc(2);
        mode_error = 2'b11;
        cyc(1);
        mode_error = 2'b00;
        rd(15, 0, 32'h3, "gstat_both");
        wr(0, 2, 32'h2);
        rd(15, 0, 32'h2, "gstat_ch1");
        chk("irq_ch1_only", irq, 1);
        wr(1, 2, 32'h2);
        chk("irq_none", irq, 0);

        // unmapped and unselected accesses
        rd(2, 0, 32'h0, "unmapped_chan");
        rd(0, 8, 32'h0, "unmapped_reg");
        rd(15, 1, 32'h0, "gstat_other_reg");
        csr_a  = {4'h1, 4'h1, 6'h0};
        csr_we = 1'b1;
        csr_di = 32'hBEEF;
        cyc(1);
        csr_we = 1'b0;
        chk("unsel_rd", csr_do, 0);
        chk("unsel_wr", mode_addr[ADDR_W +: ADDR_W], 64'h0000CAFE_00001000);
        csr_a = IDLE_A;

        // async reset while ch1 waits
        wr(1, 3, 32'h9);
        cyc(2);
        mode_irq[1] = 1'b1;
        cyc(1);
        mode_irq[1] = 1'b0;
        rd(1, 2, 32'h4, "ch1_wait");
        chk("ch1_wait_irq", irq, 1);
        #2 sys_rst = 1'b1;
        #1;
        chk("arst_start", mode_start, 0);
        chk("arst_irq", irq, 0);
        chk("arst_do", csr_do, 0);
        chk("arst_addr1", mode_addr[ADDR_W +: ADDR_W], 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        rd(1, 2, 32'h0, "post_rst_stat1");
        rd(0, 2, 32'h0, "post_rst_stat0");
        rd(1, 0, 32'h0, "post_rst_addr1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/checker_ctlif_mc.md
Name: checker_ctlif_mc

Overview:
Multi-channel successor of the checker control interface.
- Gives the LM32 a CSR window to NCHAN independent checker engines.
- Each channel has its own address, mode, start/stop, event flags, irq-ack handshake and a programmable watchdog timeout.
- A global summary register and one aggregated LM32 IRQ line cover all channels.
- Sits between the CSR bus and the checker mode engines; exposes PCIe-independent control only.

Parameters:
csr_addr, 4'h0, CSR bank select matched against csr_a[13:10]
NCHAN, 2, number of channels, 1..15
ADDR_W, 64, page address width per channel, 33..64
TMO_W, 16, watchdog counter width, 1..32

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset, asynchronous, active-high
csr_a  in  14  CSR address
csr_we  in  1  CSR write strobe
csr_di  in  32  CSR write data
csr_do  out  32  CSR read data, registered
mode_mode  out  2*NCHAN  per-channel mode, channel i at [2i+1:2i]
mode_start  out  NCHAN  per-channel run request
mode_addr  out  ADDR_W*NCHAN  per-channel page address
mode_end  in  NCHAN  engine done
mode_data  in  64*NCHAN  engine status data
mode_irq  in  NCHAN  engine mid-run interrupt request
mode_ack  out  NCHAN  one-cycle irq acknowledge
mode_error  in  NCHAN  engine error
irq  out  1  aggregated LM32 interrupt

Behaviour:
- Reset (async): csr_do=0; mode_addr=0; mode_mode=SINGLE; mode_start=0; mode_ack=0; all events, irq_en, timeout limits and counters=0; every channel in IDLE.
- Decode: selected when csr_a[13:10]==csr_addr. Channel = csr_a[9:6], register = csr_a[5:0].
- Per-channel registers:
  - 0 ADDR_LO, 1 ADDR_HI: bits above ADDR_W read 0.
  - 2 STAT: {timeout,irq,error,end} at [3:0], write-1-to-clear.
  - 3 CTRL: {start,mode[1:0],irq_en} at [3:0].
  - 4 DATA_LO, 5 DATA_HI.
  - 6 TMO_LIMIT.
  - 7 TMO_COUNT, read-only.
- Global page (channel 4'hF): register 0 GSTAT = per-channel pending vector (any event & irq_en) in bits [NCHAN-1:0].
- Unmapped channel or register reads 0; writes to it are ignored.
- Read latency: one cycle; csr_do is 0 in any cycle after an unselected access.
- Per-channel FSM, states IDLE/RUN/WAIT/ACK:
  - IDLE->RUN when mode_start=1; the counter clears on entry.
  - RUN exits, priority order: mode_end (->IDLE, start=0, end=1) > start=0 (->IDLE) > mode_error (->IDLE, start=0, error=1) > timeout (->IDLE, start=0, timeout=1) > mode_irq (->WAIT, irq=1).
  - WAIT->ACK when the irq event has been cleared; mode_ack=1 for exactly one cycle; ACK->RUN unconditionally. WAIT->IDLE if start=0 (irq event cleared).
- Watchdog: in RUN only, counter increments each cycle and saturates at all-ones. Timeout fires on the cycle count==limit with limit!=0; limit 0 disables. Counter holds in WAIT/ACK.
- Write permissions:
  - ADDR, CTRL mode/irq_en and TMO_LIMIT: writable only when that channel is IDLE.
  - CTRL start bit: writable in any state, and this CSR write wins over the FSM's start assignment in the same cycle.
  - STAT W1C: honoured only in IDLE or WAIT. Same-cycle set and clear of one bit: set wins.
- Writing start=1 while RUN/WAIT/ACK has no effect on state.
- irq = OR over channels of (any event bit & irq_en).
- Channels are fully independent; simultaneous events on different channels are all recorded.

Optional Feature:
CHECKER_CTLIF_MC_TIMEOUT_EN
- Defined: watchdog limit and counter registers are implemented as above.
- Undefined: registers 6/7 read 0 and writes are ignored, STAT bit 3 is constant 0, and the timeout transition is absent.

Decomposition:
- checker.vh shared header holds:
  - state encodings;
  - mode codes (SINGLE/AUTO/READ/DUMMY);
  - per-channel register offsets and the global page index 4'hF;
  - STAT/CTRL bit positions.
- Sub-module checker_ctlif_chan holds one channel's FSM, registers and watchdog, instantiated NCHAN times via generate.
- The top holds decode, read mux, GSTAT and irq OR.

Test Plan:
- Ch1: write ADDR_LO=0x1000, CTRL=0x9 (start, irq_en) -> mode_start[1]=1 next cycle, mode_addr ch1=0x1000; pulse mode_end[1] -> start=0, STAT=0x1, irq=1; W1C 0x1 -> irq=0.
- Ch0 running, assert mode_irq[0] -> WAIT, STAT=0x4; write STAT=0x4 -> mode_ack[0] high exactly one cycle, then RUN.
- TMO_LIMIT=10, start ch0, no end -> start=0 with TMO_COUNT=10, STAT=0x8 (macro defined); macro undefined -> channel stays RUN indefinitely.
- Same cycle: mode_end[0] and mode_error[0] -> only end flagged; write ADDR_LO during RUN -> unchanged.
- Both channels raise events with irq_en -> GSTAT=0x3; clear ch0 -> GSTAT=0x2, irq still 1.
- Assert sys_rst while ch1 in WAIT -> outputs reset immediately without a clock edge, all STAT=0.
